idex_hazard_ctrl: RTL and testbench
===================================

IDEX_HAZARD_CTRL -- requirements
Module: idex_hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_LAT, default 4, legal 2..8: total cycles a mul/div occupies EX.
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port id_valid  in  1  ID stage holds a live instruction.
REQ-006 SHALL have ports id_rs1, id_rs2  in  5 each  ID source registers.
REQ-007 SHALL have ports id_use_rs1, id_use_rs2  in  1 each  ID instruction reads rs1/rs2.
REQ-008 SHALL have port id_muldiv  in  1  ID instruction is multi-cycle mul/div.
REQ-009 SHALL have port ex_valid  in  1  ID/EX register holds a live instruction.
REQ-010 SHALL have port ex_rd  in  5  EX destination register.
REQ-011 SHALL have port ex_load  in  1  EX instruction is a load.
REQ-012 SHALL have port ex_annul  in  1  branch in EX annuls its delay slot (the instruction now in ID).
REQ-013 SHALL have port stat_clr  in  1  synchronous clear of stall_count.
REQ-014 SHALL have ports pc_stall, ifid_stall  out  1 each  hold PC and IF/ID register.
REQ-015 SHALL have port idex_bubble  out  1  load zeros (NOP) into ID/EX next edge.
REQ-016 SHALL have port idex_hold  out  1  ID/EX register keeps its contents next edge.
REQ-017 SHALL have port md_busy  out  1  FSM in MD_BUSY.
REQ-018 SHALL have port stall_count  out  16  saturating count of pc_stall cycles.

Function
REQ-019 SHALL implement FSM with states RUN and MD_BUSY plus 4-bit down-counter md_cnt.
REQ-020 SHALL define hazard LU = id_valid & ex_valid & ex_load & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-021 SHALL, in RUN with ex_annul=1: idex_bubble=1, pc_stall=ifid_stall=0, idex_hold=0, no state change; annul overrides LU and id_muldiv.
REQ-022 SHALL, in RUN with ex_annul=0 and LU=1: pc_stall=ifid_stall=idex_bubble=1 same cycle (combinational); state stays RUN; one-cycle stall results because the bubble clears ex_valid.
REQ-023 SHALL, in RUN with ex_annul=0, LU=0, id_valid=1, id_muldiv=1: all outputs 0 this cycle; next state MD_BUSY, md_cnt loaded with MD_LAT-2.
REQ-024 SHALL, in MD_BUSY: pc_stall=ifid_stall=idex_hold=md_busy=1, idex_bubble=0; all ex_* and id_* inputs ignored.
REQ-025 SHALL, in MD_BUSY: if md_cnt==0 next state RUN, else md_cnt decrements; mul/div thus occupies EX exactly MD_LAT cycles.
REQ-026 SHALL drive all control outputs 0 in RUN when none of REQ-021..023 apply.
REQ-027 SHALL never assert idex_bubble and idex_hold together.
REQ-028 SHALL increment stall_count on each edge where pc_stall=1; hold at 16'hFFFF; stat_clr=1 forces 0 and takes priority over increment.
REQ-029 SHALL treat ex_rd==0 (%g0) as never hazarding.

Reset
REQ-030 SHALL on reset low immediately force state RUN, md_cnt=0, stall_count=0; with all inputs 0 every output reads 0.
REQ-031 SHALL abort an in-progress MD_BUSY on reset assertion; first edge after release evaluates in RUN.

Verification
REQ-032 Load-use: ex_valid=1, ex_load=1, ex_rd=5; id_valid=1, id_use_rs2=1, id_rs2=5 -> pc_stall=ifid_stall=idex_bubble=1 one cycle; next cycle (ex_valid=0) all 0; stall_count=1.
REQ-033 %g0 and unused operand: ex_rd=0 matching id_rs1=0, then ex_rd=7 with id_rs1=7, id_use_rs1=0 -> no stall either case.
REQ-034 Mul/div MD_LAT=4: id_muldiv=1 issued cycle 0 -> md_busy=1 and idex_hold=1 cycles 1..3, RUN at cycle 4; stall_count=3.
REQ-035 Annul priority: ex_annul=1 together with LU=1 and id_muldiv=1 -> idex_bubble=1 only, pc_stall=0, state stays RUN.
REQ-036 Reset mid-op: reset low in cycle 2 of MD_BUSY -> md_busy=0, stall_count=0 asynchronously; normal RUN after release.
REQ-037 Saturation/clear: force 65537 stall cycles -> stall_count=16'hFFFF; stat_clr=1 with pc_stall=1 -> 0.

Source files
------------

// File: rtl/idex_hazard_ctrl.sv
// ID/EX hazard controller: load-use stall, branch-annul bubble and multi-cycle mul/div hold,
// plus a saturating stall-cycle counter.
module idex_hazard_ctrl #(
  parameter int unsigned MD_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        id_muldiv,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd,
  input  logic        ex_load,
  input  logic        ex_annul,
  input  logic        stat_clr,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        idex_bubble,
  output logic        idex_hold,
  output logic        md_busy,
  output logic [15:0] stall_count
);

  typedef enum logic {StRun, StMdBusy} state_e;

  state_e      state_q, state_d;
  logic [3:0]  md_cnt_q, md_cnt_d;
  logic [15:0] stall_count_q, stall_count_d;
  logic        load_use;

  // %g0 never carries a dependency, so ex_rd == 0 can never hazard.
  assign load_use = id_valid & ex_valid & ex_load & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_bubble = 1'b0;
    idex_hold   = 1'b0;
    md_busy     = 1'b0;
    unique case (state_q)
      StRun: begin
        if (ex_annul) begin
          idex_bubble = 1'b1;
        end else if (load_use) begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_bubble = 1'b1;
        end else if (id_valid && id_muldiv) begin
          // Issue cycle counts as the first EX cycle; busy covers the remaining MD_LAT-1.
          state_d  = StMdBusy;
          md_cnt_d = 4'(MD_LAT - 2);
        end
      end
      StMdBusy: begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_hold  = 1'b1;
        md_busy    = 1'b1;
        if (md_cnt_q == 4'd0) begin
          state_d = StRun;
        end else begin
          md_cnt_d = md_cnt_q - 4'd1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stat_clr) begin
      stall_count_d = 16'd0;
    end else if (pc_stall && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StRun;
      md_cnt_q      <= 4'd0;
      stall_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      md_cnt_q      <= md_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// Directed bench for idex_hazard_ctrl with MD_LAT = 4.
module tb_idex_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_use_rs1, id_use_rs2, id_muldiv;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        ex_valid, ex_load, ex_annul, stat_clr;
  logic        pc_stall, ifid_stall, idex_bubble, idex_hold, md_busy;
  logic [15:0] stall_count;

  int passed = 0;
  int total  = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  idex_hazard_ctrl #(.MD_LAT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .id_muldiv  (id_muldiv),
    .ex_valid   (ex_valid),
    .ex_rd      (ex_rd),
    .ex_load    (ex_load),
    .ex_annul   (ex_annul),
    .stat_clr   (stat_clr),
    .pc_stall   (pc_stall),
    .ifid_stall (ifid_stall),
    .idex_bubble(idex_bubble),
    .idex_hold  (idex_hold),
    .md_busy    (md_busy),
    .stall_count(stall_count)
  );

  task automatic clear_inputs();
    id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_muldiv = 0;
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    ex_valid = 0; ex_load = 0; ex_annul = 0; stat_clr = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load in EX writes r5, ID reads r5 through rs2.
  task automatic drive_load_use();
    ex_valid = 1; ex_load = 1; ex_rd = 5'd5;
    id_valid = 1; id_use_rs2 = 1; id_rs2 = 5'd5;
  endtask

  task automatic test_reset();
    reset = 0;
    clear_inputs();
    #3;
    total++; if (pc_stall !== 1'b0) $display("FAIL reset_pc_stall got %b want 0", pc_stall); else passed++;
    total++; if (ifid_stall !== 1'b0) $display("FAIL reset_ifid_stall got %b want 0", ifid_stall); else passed++;
    total++; if (idex_bubble !== 1'b0) $display("FAIL reset_bubble got %b want 0", idex_bubble); else passed++;
    total++; if (idex_hold !== 1'b0) $display("FAIL reset_hold got %b want 0", idex_hold); else passed++;
    total++; if (md_busy !== 1'b0) $display("FAIL reset_md_busy got %b want 0", md_busy); else passed++;
    total++; if (stall_count !== 16'd0) $display("FAIL reset_count got %0d want 0", stall_count); else passed++;
    step();
    reset = 1;
    exp_cnt = 0;
    step();
  endtask

  task automatic test_load_use();
    drive_load_use();
    #1;
    total++; if (pc_stall !== 1'b1) $display("FAIL lu_pc_stall got %b want 1", pc_stall); else passed++;
    total++; if (ifid_stall !== 1'b1) $display("FAIL lu_ifid_stall got %b want 1", ifid_stall); else passed++;
    total++; if (idex_bubble !== 1'b1) $display("FAIL lu_bubble got %b want 1", idex_bubble); else passed++;
    total++; if (idex_hold !== 1'b0) $display("FAIL lu_hold got %b want 0", idex_hold); else passed++;
    step();
    exp_cnt++;
    ex_valid = 0;
    #1;
    total++; if (pc_stall !== 1'b0) $display("FAIL lu_after_pc_stall got %b want 0", pc_stall); else passed++;
    total++; if (idex_bubble !== 1'b0) $display("FAIL lu_after_bubble got %b want 0", idex_bubble); else passed++;
    total++; if (stall_count !== 16'(exp_cnt)) $display("FAIL lu_count got %0d want %0d", stall_count, exp_cnt); else passed++;
    clear_inputs();
    step();
  endtask

  task automatic test_g0_and_unused();
    ex_valid = 1; ex_load = 1; ex_rd = 5'd0;
    id_valid = 1; id_use_rs1 = 1; id_rs1 = 5'd0; id_use_rs2 = 1; id_rs2 = 5'd0;
    #1;
    total++; if (pc_stall !== 1'b0) $display("FAIL g0_pc_stall got %b want 0", pc_stall); else passed++;
    total++; if (idex_bubble !== 1'b0) $display("FAIL g0_bubble got %b want 0", idex_bubble); else passed++;
    ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 0; id_use_rs2 = 0;
    #1;
    total++; if (pc_stall !== 1'b0) $display("FAIL unused_pc_stall got %b want 0", pc_stall); else passed++;
    id_use_rs1 = 1;
    #1;
    total++; if (pc_stall !== 1'b1) $display("FAIL rs1_match_pc_stall got %b want 1", pc_stall); else passed++;
    ex_load = 0;
    #1;
    total++; if (pc_stall !== 1'b0) $display("FAIL nonload_pc_stall got %b want 0", pc_stall); else passed++;
    clear_inputs();
    step();
    total++; if (stall_count !== 16'(exp_cnt)) $display("FAIL g0_count got %0d want %0d", stall_count, exp_cnt); else passed++;
  endtask

  task automatic test_muldiv();
    id_valid = 1; id_muldiv = 1;
    #1;
    total++; if (pc_stall !== 1'b0) $display("FAIL md_issue_pc_stall got %b want 0", pc_stall); else passed++;
    total++; if (md_busy !== 1'b0) $display("FAIL md_issue_busy got %b want 0", md_busy); else passed++;
    total++; if (idex_hold !== 1'b0) $display("FAIL md_issue_hold got %b want 0", idex_hold); else passed++;
    step();
    // Inputs that would otherwise bubble or stall must be ignored while busy.
    clear_inputs();
    drive_load_use();
    ex_annul = 1; id_muldiv = 1;
    for (int c = 1; c <= 3; c++) begin
      #1;
      total++; if (md_busy !== 1'b1) $display("FAIL md_busy_c%0d got %b want 1", c, md_busy); else passed++;
      total++; if (idex_hold !== 1'b1) $display("FAIL md_hold_c%0d got %b want 1", c, idex_hold); else passed++;
      total++; if (idex_bubble !== 1'b0) $display("FAIL md_bubble_c%0d got %b want 0", c, idex_bubble); else passed++;
      total++; if (pc_stall !== 1'b1) $display("FAIL md_pc_stall_c%0d got %b want 1", c, pc_stall); else passed++;
      @(posedge clk);
      exp_cnt++;
    end
    #1;
    clear_inputs();
    #1;
    total++; if (md_busy !== 1'b0) $display("FAIL md_done_busy got %b want 0", md_busy); else passed++;
    total++; if (pc_stall !== 1'b0) $display("FAIL md_done_pc_stall got %b want 0", pc_stall); else passed++;
    total++; if (stall_count !== 16'(exp_cnt)) $display("FAIL md_count got %0d want %0d", stall_count, exp_cnt); else passed++;
    step();
  endtask

  task automatic test_annul_priority();
    drive_load_use();
    id_muldiv = 1; ex_annul = 1;
    #1;
    total++; if (idex_bubble !== 1'b1) $display("FAIL annul_bubble got %b want 1", idex_bubble); else passed++;
    total++; if (pc_stall !== 1'b0) $display("FAIL annul_pc_stall got %b want 0", pc_stall); else passed++;
    total++; if (ifid_stall !== 1'b0) $display("FAIL annul_ifid_stall got %b want 0", ifid_stall); else passed++;
    total++; if (idex_hold !== 1'b0) $display("FAIL annul_hold got %b want 0", idex_hold); else passed++;
    step();
    clear_inputs();
    #1;
    total++; if (md_busy !== 1'b0) $display("FAIL annul_state got md_busy %b want 0", md_busy); else passed++;
    total++; if (stall_count !== 16'(exp_cnt)) $display("FAIL annul_count got %0d want %0d", stall_count, exp_cnt); else passed++;
    step();
  endtask

  task automatic test_reset_mid_op();
    id_valid = 1; id_muldiv = 1;
    step();
    clear_inputs();
    step();
    #2;
    reset = 0;
    #1;
    exp_cnt = 0;
    total++; if (md_busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", md_busy); else passed++;
    total++; if (stall_count !== 16'd0) $display("FAIL rstmid_count got %0d want 0", stall_count); else passed++;
    total++; if (idex_hold !== 1'b0) $display("FAIL rstmid_hold got %b want 0", idex_hold); else passed++;
    step();
    reset = 1;
    step();
    total++; if (md_busy !== 1'b0) $display("FAIL rstmid_after_busy got %b want 0", md_busy); else passed++;
    drive_load_use();
    #1;
    total++; if (pc_stall !== 1'b1) $display("FAIL rstmid_after_lu got %b want 1", pc_stall); else passed++;
    clear_inputs();
    step();
  endtask

  task automatic test_saturation();
    drive_load_use();
    repeat (65537) @(posedge clk);
    #1;
    total++; if (stall_count !== 16'hFFFF) $display("FAIL sat_count got %h want ffff", stall_count); else passed++;
    stat_clr = 1;
    total++; if (pc_stall !== 1'b1) $display("FAIL sat_pc_stall got %b want 1", pc_stall); else passed++;
    step();
    total++; if (stall_count !== 16'd0) $display("FAIL clr_count got %0d want 0", stall_count); else passed++;
    stat_clr = 0;
    step();
    total++; if (stall_count !== 16'd1) $display("FAIL post_clr_count got %0d want 1", stall_count); else passed++;
    clear_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_g0_and_unused();
    test_muldiv();
    test_annul_priority();
    test_reset_mid_op();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
